mem_stage_pipe: RTL and testbench

Parametrised MEM/WB pipeline stage for the 18-bit core: performs the data-memory access for the instruction in MEM and registers its results into the write-back stage. It replaces the fixed single-cycle memory stage. It adds configurable widths, multi-cycle load latency with an upstream stall request, hazard-unit hold/flush, and out-of-range address detection.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_stage_pipe_if.sv | 43 ++++
 rtl/mem_sp_ram.sv | 35 +++
 rtl/mem_stage_pipe.sv | 131 +++++++++++++
 tb/tb_mem_stage_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the MEM/WB stage of the 18-bit core.
package mem_pkg;

    localparam int unsigned DATA_W_DEF  = 18;
    localparam int unsigned ADDR_W_DEF  = 9;
    localparam int unsigned RD_W_DEF    = 5;
    localparam int unsigned PC_W_DEF    = 9;
    localparam int unsigned MEM_LAT_MAX = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // WB control flags; the data fields are width-parametrised in the stage itself
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic result_src;
        logic addr_err;
    } wb_bus_t;

endpackage

// File: rtl/mem_stage_pipe_if.sv
// MEM-stage inputs, hazard controls and WB-stage outputs of the memory pipeline stage.
interface mem_stage_pipe_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_W   = RD_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF
);
    logic              valid_m;
    logic              reg_write_m;
    logic              mem_write_m;
    logic              mem_read_m;
    logic [RD_W-1:0]   rd_m;
    logic [PC_W-1:0]   pc_plus4_m;
    logic [DATA_W-1:0] alu_result_m;
    logic [DATA_W-1:0] write_data_m;
    logic              hold_i;
    logic              flush_i;
    logic              busy_o;
    logic              valid_w;
    logic              reg_write_w;
    logic              result_src_w;
    logic              addr_err_w;
    logic [RD_W-1:0]   rd_w;
    logic [PC_W-1:0]   pc_plus4_w;
    logic [DATA_W-1:0] alu_result_w;
    logic [DATA_W-1:0] read_data_w;

    modport master (
        output valid_m, reg_write_m, mem_write_m, mem_read_m, rd_m, pc_plus4_m,
               alu_result_m, write_data_m, hold_i, flush_i,
        input  busy_o, valid_w, reg_write_w, result_src_w, addr_err_w, rd_w,
               pc_plus4_w, alu_result_w, read_data_w
    );

    modport slave (
        input  valid_m, reg_write_m, mem_write_m, mem_read_m, rd_m, pc_plus4_m,
               alu_result_m, write_data_m, hold_i, flush_i,
        output busy_o, valid_w, reg_write_w, result_src_w, addr_err_w, rd_w,
               pc_plus4_w, alu_result_w, read_data_w
    );

endinterface

// File: rtl/mem_sp_ram.sv
// Single-port data RAM: synchronous write, read data MEM_LAT-1 register stages after the address.
module mem_sp_ram #(
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    generate
        if (MEM_LAT == 1) begin : g_comb
            assign rdata = mem[addr];
        end else begin : g_pipe
            logic [DATA_W-1:0] stage [MEM_LAT-1];

            always_ff @(posedge clk) begin
                stage[0] <= mem[addr];
                for (int unsigned i = 1; i < MEM_LAT - 1; i++) stage[i] <= stage[i-1];
            end

            assign rdata = stage[MEM_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM/WB pipeline stage: data-memory access with multi-cycle loads, hazard hold/flush
// and out-of-range address detection, registered into the write-back stage.
module mem_stage_pipe
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned RD_W    = RD_W_DEF,
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_stage_pipe_if.slave bus
);

    localparam int unsigned     CNT_W    = $clog2(MEM_LAT_MAX);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
    localparam bit              MULTI    = (MEM_LAT > 1);

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              busy;
    logic              in_range;
    logic              is_load;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    wb_bus_t           wb_flags;
    logic [RD_W-1:0]   rd_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata_q;

    assign in_range = (bus.alu_result_m[DATA_W-1:ADDR_W] == '0);
    assign is_load  = bus.valid_m & bus.mem_read_m;
    assign ram_we   = rst & (state == IDLE) & bus.valid_m & bus.mem_write_m
                    & ~bus.hold_i & ~bus.flush_i & in_range;

    mem_sp_ram #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.alu_result_m[ADDR_W-1:0]),
        .wdata (bus.write_data_m),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        busy      = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (is_load && MULTI) begin
                    busy      = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    busy    = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.hold_i) begin
            state_nxt = state;
            cnt_nxt   = cnt;
        end
        if (bus.flush_i) begin
            busy      = 1'b0;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
        if (!rst) busy = 1'b0;
    end

    // flush outranks hold; busy bubbles only when not held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_flags <= '0;
            rd_q     <= '0;
            pc_q     <= '0;
            alu_q    <= '0;
            rdata_q  <= '0;
        end else if (bus.flush_i || (busy && !bus.hold_i)) begin
            wb_flags.valid     <= 1'b0;
            wb_flags.reg_write <= 1'b0;
            wb_flags.addr_err  <= 1'b0;
        end else if (!bus.hold_i) begin
            wb_flags.valid      <= bus.valid_m;
            wb_flags.reg_write  <= bus.valid_m & bus.reg_write_m;
            wb_flags.result_src <= bus.mem_read_m;
            wb_flags.addr_err   <= bus.valid_m & (bus.mem_read_m | bus.mem_write_m) & ~in_range;
            rd_q                <= bus.rd_m;
            pc_q                <= bus.pc_plus4_m;
            alu_q               <= bus.alu_result_m;
            rdata_q             <= in_range ? ram_rdata : '0;
        end
    end

    assign bus.busy_o       = busy;
    assign bus.valid_w      = wb_flags.valid;
    assign bus.reg_write_w  = wb_flags.reg_write;
    assign bus.result_src_w = wb_flags.result_src;
    assign bus.addr_err_w   = wb_flags.addr_err;
    assign bus.rd_w         = rd_q;
    assign bus.pc_plus4_w   = pc_q;
    assign bus.alu_result_w = alu_q;
    assign bus.read_data_w  = rdata_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: one instance with single-cycle loads, one with 3-cycle loads.
module tb_mem_stage_pipe;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_pipe_if #(.DATA_W(18), .RD_W(5), .PC_W(9)) bus1 ();
    mem_stage_pipe_if #(.DATA_W(18), .RD_W(5), .PC_W(9)) bus3 ();

    mem_stage_pipe #(
        .DATA_W(18), .ADDR_W(9), .RD_W(5), .PC_W(9), .MEM_LAT(1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_stage_pipe #(
        .DATA_W(18), .ADDR_W(9), .RD_W(5), .PC_W(9), .MEM_LAT(3)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic v, rw, mw, mr, input logic [4:0] rd,
                        input logic [8:0] pc, input logic [17:0] alu, wd);
        bus1.valid_m = v;  bus1.reg_write_m = rw; bus1.mem_write_m = mw; bus1.mem_read_m = mr;
        bus1.rd_m = rd;    bus1.pc_plus4_m = pc;  bus1.alu_result_m = alu; bus1.write_data_m = wd;
    endtask

    task automatic set3(input logic v, rw, mw, mr, input logic [4:0] rd,
                        input logic [8:0] pc, input logic [17:0] alu, wd);
        bus3.valid_m = v;  bus3.reg_write_m = rw; bus3.mem_write_m = mw; bus3.mem_read_m = mr;
        bus3.rd_m = rd;    bus3.pc_plus4_m = pc;  bus3.alu_result_m = alu; bus3.write_data_m = wd;
    endtask

    function automatic logic [3:0] flags1();
        return {bus1.valid_w, bus1.reg_write_w, bus1.result_src_w, bus1.addr_err_w};
    endfunction

    function automatic logic [3:0] flags3();
        return {bus3.valid_w, bus3.reg_write_w, bus3.result_src_w, bus3.addr_err_w};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus1.hold_i = 1'b0; bus1.flush_i = 1'b0;
        bus3.hold_i = 1'b0; bus3.flush_i = 1'b0;
        set1(1, 1, 1, 1, 5'h1F, 9'h1FF, 18'h00020, 18'h3FFFF);
        set3(1, 1, 1, 1, 5'h1F, 9'h1FF, 18'h00020, 18'h3FFFF);
        tick; tick;
        check("rst1_flags", flags1(), 4'h0);
        check("rst1_rd", bus1.rd_w, 0);
        check("rst1_pc", bus1.pc_plus4_w, 0);
        check("rst1_alu", bus1.alu_result_w, 0);
        check("rst1_rdata", bus1.read_data_w, 0);
        check("rst1_busy", bus1.busy_o, 0);
        check("rst3_flags", flags3(), 4'h0);
        check("rst3_busy", bus3.busy_o, 0);

        // store 020 = 12345, then reset with a junk store to the same word
        rst = 1'b1;
        set3(0, 0, 0, 0, 0, 0, 0, 0);
        set1(1, 0, 1, 0, 0, 0, 18'h00020, 18'h12345);
        #1 check("st020_busy", bus1.busy_o, 0);
        tick;
        check("st020_flags", flags1(), 4'b1000);
        rst = 1'b0;
        set1(1, 1, 1, 0, 5'h1F, 9'h1FF, 18'h00020, 18'h3FFFF);
        tick; tick;
        check("rst2_flags", flags1(), 4'h0);
        rst = 1'b1;
        set1(1, 1, 0, 1, 5'd3, 9'h044, 18'h00020, 0);
        #1 check("ld020_busy", bus1.busy_o, 0);
        tick;
        check("ld020_rdata", bus1.read_data_w, 18'h12345);
        check("ld020_rd", bus1.rd_w, 3);
        check("ld020_flags", flags1(), 4'b1110);
        check("ld020_pc", bus1.pc_plus4_w, 9'h044);
        check("ld020_alu", bus1.alu_result_w, 18'h00020);

        // store then immediate load of the same word
        set1(1, 0, 1, 0, 0, 0, 18'h00010, 18'h2ABCD);
        #1 check("st010_busy", bus1.busy_o, 0);
        tick;
        check("st010_flags", flags1(), 4'b1000);
        set1(1, 1, 0, 1, 5'd7, 9'h100, 18'h00010, 0);
        #1 check("ld010_busy", bus1.busy_o, 0);
        tick;
        check("ld010_rdata", bus1.read_data_w, 18'h2ABCD);
        check("ld010_rd", bus1.rd_w, 7);
        check("ld010_flags", flags1(), 4'b1110);

        // out-of-range access aliases word 000 but must not touch it
        set1(1, 0, 1, 0, 0, 0, 18'h00000, 18'h00555);
        tick;
        set1(1, 1, 0, 1, 5'd9, 0, 18'h00200, 0);
        tick;
        check("oor_ld_rdata", bus1.read_data_w, 0);
        check("oor_ld_flags", flags1(), 4'b1111);
        set1(1, 0, 1, 0, 0, 0, 18'h00200, 18'h3FFFF);
        tick;
        check("oor_st_flags", flags1(), 4'b1001);
        set1(1, 1, 0, 1, 5'd10, 0, 18'h00000, 0);
        tick;
        check("rb000_rdata", bus1.read_data_w, 18'h00555);
        check("rb000_flags", flags1(), 4'b1110);

        // non-memory op with high address bits, then a bubble
        set1(1, 1, 0, 0, 5'd4, 9'h0F0, 18'h3F000, 0);
        tick;
        check("alu_flags", flags1(), 4'b1100);
        check("alu_result", bus1.alu_result_w, 18'h3F000);
        check("alu_pc", bus1.pc_plus4_w, 9'h0F0);
        set1(0, 1, 0, 0, 5'd5, 0, 18'h00001, 0);
        tick;
        check("bubble_flags", flags1(), 4'b0000);

        // store under hold on the single-cycle instance
        set1(1, 1, 0, 0, 5'd11, 0, 0, 0);
        tick;
        set1(1, 0, 1, 0, 5'd12, 0, 18'h00030, 18'h11111);
        bus1.hold_i = 1'b1;
        tick;
        check("hold1_rd_a", bus1.rd_w, 11);
        check("hold1_flags_a", flags1(), 4'b1100);
        tick;
        check("hold1_rd_b", bus1.rd_w, 11);
        bus1.hold_i = 1'b0;
        tick;
        check("hold1_st_flags", flags1(), 4'b1000);
        check("hold1_st_rd", bus1.rd_w, 12);
        set1(1, 1, 0, 1, 5'd13, 0, 18'h00030, 0);
        tick;
        check("hold1_rb", bus1.read_data_w, 18'h11111);

        // flush and hold together: flush wins
        set1(1, 1, 0, 0, 5'd14, 0, 0, 0);
        bus1.hold_i = 1'b1; bus1.flush_i = 1'b1;
        tick;
        check("fh_vld_rw", {bus1.valid_w, bus1.reg_write_w}, 2'b00);
        check("fh_rd", bus1.rd_w, 13);
        bus1.hold_i = 1'b0; bus1.flush_i = 1'b0;
        set1(0, 0, 0, 0, 0, 0, 0, 0);

        // three-cycle load
        set3(1, 0, 1, 0, 5'd2, 0, 18'h00040, 18'h0ABCD);
        #1 check("l3_st_busy", bus3.busy_o, 0);
        tick;
        check("l3_st_flags", flags3(), 4'b1000);
        set3(1, 1, 0, 1, 5'd5, 9'h0AA, 18'h00040, 0);
        #1 check("l3_issue_busy", bus3.busy_o, 1);
        tick;
        check("l3_e1_vld_rw", {bus3.valid_w, bus3.reg_write_w}, 2'b00);
        check("l3_e1_busy", bus3.busy_o, 1);
        check("l3_e1_rd", bus3.rd_w, 2);
        tick;
        check("l3_e2_vld_rw", {bus3.valid_w, bus3.reg_write_w}, 2'b00);
        check("l3_e2_busy", bus3.busy_o, 0);
        tick;
        check("l3_e3_rdata", bus3.read_data_w, 18'h0ABCD);
        check("l3_e3_rd", bus3.rd_w, 5);
        check("l3_e3_flags", flags3(), 4'b1110);
        set3(1, 0, 1, 0, 5'd2, 0, 18'h00041, 18'h15555);
        #1 check("l3_st2_busy", bus3.busy_o, 0);
        tick;
        check("l3_st2_flags", flags3(), 4'b1000);

        // hold for two cycles in the middle of the wait
        set3(1, 1, 0, 1, 5'd6, 0, 18'h00041, 0);
        tick;
        bus3.hold_i = 1'b1;
        #1 check("h3_busy", bus3.busy_o, 1);
        tick;
        check("h3_a_rd", bus3.rd_w, 2);
        check("h3_a_valid", bus3.valid_w, 0);
        tick;
        check("h3_b_rd", bus3.rd_w, 2);
        check("h3_b_valid", bus3.valid_w, 0);
        bus3.hold_i = 1'b0;
        tick;
        check("h3_c_valid", bus3.valid_w, 0);
        check("h3_c_busy", bus3.busy_o, 0);
        tick;
        check("h3_d_rdata", bus3.read_data_w, 18'h15555);
        check("h3_d_rd", bus3.rd_w, 6);
        check("h3_d_flags", flags3(), 4'b1110);

        // flush in the wait aborts to idle
        set3(1, 1, 0, 1, 5'd8, 0, 18'h00040, 0);
        tick;
        bus3.flush_i = 1'b1;
        #1 check("f3_busy", bus3.busy_o, 0);
        tick;
        check("f3_vld_rw", {bus3.valid_w, bus3.reg_write_w}, 2'b00);
        bus3.flush_i = 1'b0;
        set3(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        set3(1, 1, 0, 1, 5'd9, 0, 18'h00041, 0);
        #1 check("f3_re_busy0", bus3.busy_o, 1);
        tick;
        check("f3_re_busy1", bus3.busy_o, 1);
        tick;
        check("f3_re_busy2", bus3.busy_o, 0);
        tick;
        check("f3_re_rdata", bus3.read_data_w, 18'h15555);
        check("f3_re_rd", bus3.rd_w, 9);
        check("f3_re_flags", flags3(), 4'b1110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
